// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared widths, bus types and refill FSM encodings for the instruction cache
package icache_dm_pkg;
  localparam int ICACHE_INDEX_W = 6;
  localparam int ICACHE_OFFSET_W = 3;
  localparam int STALL_W = 6;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef logic [31:0] inst_addr_t;
  typedef logic [STALL_W-1:0] stall_t;
  typedef enum logic [1:0] {
    ICS_IDLE = 2'd0,
    ICS_REFILL = 2'd1,
    ICS_DONE = 2'd2
  } ics_e;
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and refill-side signals of the instruction cache
interface icache_dm_if;
  import icache_dm_pkg::*;
  stall_t stall;
  logic flush;
  inst_addr_t icache_pc;
  logic icache_ce;
  inst_addr_t inst;
  logic inst_valid;
  logic stallreq;
  logic mem_req;
  inst_addr_t mem_addr;
  logic mem_rvalid;
  inst_addr_t mem_rdata;
  modport slave (
    input stall, flush, icache_pc, icache_ce, mem_rvalid, mem_rdata,
    output inst, inst_valid, stallreq, mem_req, mem_addr
  );
  modport master (
    output stall, flush, icache_pc, icache_ce, mem_rvalid, mem_rdata,
    input inst, inst_valid, stallreq, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: miss sequencing, beat counting and line-refill strobes for icache_dm
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int OFFSET_W = ICACHE_OFFSET_W,
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [TAG_W-1:0] miss_tag,
  input  logic [INDEX_W-1:0] miss_idx,
  input  logic mem_rvalid,
  output logic idle,
  output logic mem_req,
  output logic [31:0] mem_addr,
  output logic clr,
  output logic we,
  output logic install,
  output logic [INDEX_W-1:0] wr_idx,
  output logic [OFFSET_W-1:0] wr_off,
  output logic [TAG_W-1:0] wr_tag
);
  ics_e state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    addr_d = addr_q;
    idx_d = idx_q;
    tag_d = tag_q;
    clr = 1'b0;
    we = 1'b0;
    install = 1'b0;
    case (state_q)
      ICS_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ICS_REFILL;
          req_d = 1'b1;
          addr_d = {miss_tag, miss_idx, {(OFFSET_W+2){1'b0}}};
          idx_d = miss_idx;
          tag_d = miss_tag;
          clr = 1'b1;
        end
      end
      ICS_REFILL: begin
        if (mem_rvalid) begin
          we = 1'b1;
          cnt_d = cnt_q + 1'b1;
          // last beat installs the line; the valid bit was cleared on entry
          if (&cnt_q) begin
            req_d = 1'b0;
            install = 1'b1;
            state_d = ICS_DONE;
          end
        end
      end
      default: state_d = ICS_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ICS_IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
      addr_q <= '0;
      idx_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      tag_q <= tag_d;
    end
  end
  assign idle = state_q == ICS_IDLE;
  assign mem_req = req_q;
  assign mem_addr = addr_q;
  assign wr_idx = idx_q;
  assign wr_off = cnt_q;
  assign wr_tag = tag_q;
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with combinational hit path and beat-based line refill
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int OFFSET_W = ICACHE_OFFSET_W
) (
  input logic clk,
  input logic rst,
  icache_dm_if.slave bus
);
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES][WORDS];
  logic [OFFSET_W-1:0] pc_off, wr_off;
  logic [INDEX_W-1:0] pc_idx, wr_idx;
  logic [TAG_W-1:0] pc_tag, wr_tag;
  logic idle, clr, we, install, hit, unused_ok;
  assign pc_off = bus.icache_pc[OFFSET_W+1:2];
  assign pc_idx = bus.icache_pc[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign pc_tag = bus.icache_pc[31:INDEX_W+OFFSET_W+2];
  // stall is not needed: the upstream register holds icache_pc steady
  assign unused_ok = ^{bus.stall, bus.icache_pc[1:0]};
  assign hit = bus.icache_ce & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag) & idle;
  assign bus.inst = hit ? data_q[pc_idx][pc_off] : ZERO_WORD;
  assign bus.inst_valid = hit;
  assign bus.stallreq = ~idle | (bus.icache_ce & ~hit);
  icache_refill_fsm #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) u_fsm (
    .clk(clk),
    .rst(rst),
    .start(bus.icache_ce & ~hit & ~bus.flush),
    .miss_tag(pc_tag),
    .miss_idx(pc_idx),
    .mem_rvalid(bus.mem_rvalid),
    .idle(idle),
    .mem_req(bus.mem_req),
    .mem_addr(bus.mem_addr),
    .clr(clr),
    .we(we),
    .install(install),
    .wr_idx(wr_idx),
    .wr_off(wr_off),
    .wr_tag(wr_tag)
  );
  always_comb begin
    valid_d = valid_q;
    if (clr) valid_d[pc_idx] = 1'b0;
    if (install) valid_d[wr_idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk) begin
    if (we) data_q[wr_idx][wr_off] <= bus.mem_rdata;
    if (install) tag_q[wr_idx] <= wr_tag;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache.
- Sits directly downstream of the PC-to-icache pipeline register.
- Consumes the registered fetch address and enable (icache_pc / icache_ce).
- Returns the instruction word combinationally on a hit.
- On a miss: raises a stall request to the stall controller and refills one line over a simple beat-based memory read interface.

Parameters:
- INDEX_W, 6, line index bits (64 lines).
- OFFSET_W, 3, word-offset bits (8 words / 32-byte line).
- TAG_W is derived: 32 - INDEX_W - OFFSET_W - 2 (21 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- stall  in  `StallBus  pipeline stall vector; this stage is bit 2.
- flush  in  1  pipeline flush.
- icache_pc  in  `InstAddrBus  registered fetch address.
- icache_ce  in  1  fetch enable.
- inst  out  `InstAddrBus (32)  instruction word; `ZeroWord when not a valid hit.
- inst_valid  out  1  inst is a hit for the current icache_pc.
- stallreq  out  1  request to stall stages 0..2.
- mem_req  out  1  refill request, held until the last beat is accepted.
- mem_addr  out  32  line-aligned refill address.
- mem_rvalid  in  1  refill data beat valid.
- mem_rdata  in  32  refill data beat.

Behaviour:
- Address split:
  - [1:0] ignored.
  - [OFFSET_W+1:2] word offset.
  - [INDEX_W+OFFSET_W+1:OFFSET_W+2] index.
  - Upper bits are the tag.
- Storage:
  - Arrays: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W][2^OFFSET_W].
  - Read is combinational; write is synchronous.
- hit = icache_ce & valid[idx] & (tag[idx] == pc_tag) & (state == IDLE).
- inst = hit ? data[idx][off] : `ZeroWord.
- inst_valid = hit.
- stallreq = (state != IDLE) | (icache_ce & ~hit).
- FSM states: IDLE, REFILL, DONE.
  - IDLE:
    - On icache_ce & miss & ~flush: latch miss tag/idx, go to REFILL.
    - Set mem_req=1 and mem_addr={tag,idx,(OFFSET_W+2)'b0}, registered so both appear the next cycle.
    - Beat counter is cleared to 0.
  - REFILL:
    - Each cycle with mem_rvalid: write mem_rdata to data[latched idx][cnt] and increment cnt.
    - mem_rvalid gaps of any length are tolerated; mem_addr and mem_req stay stable.
    - On the beat where cnt == 2^OFFSET_W-1:
      - drop mem_req;
      - set valid[idx]=1 and tag[idx]=latched tag;
      - go to DONE.
    - valid[idx] is cleared on REFILL entry, so a partially written line is never hit.
  - DONE: one bubble cycle, then IDLE. The re-lookup in IDLE then hits, so miss-to-inst latency = 2 + beats + 1 cycles.
- flush:
  - Never aborts an in-flight refill; the line completes and is installed.
  - In IDLE, flush suppresses starting a new refill that cycle.
  - stallreq still follows the formula above.
- stall: the cache does not gate on stall. icache_pc is held by the upstream register, so a hit output stays stable while stalled.
- icache_ce=0: no lookup, no refill, inst=`ZeroWord, stallreq=0 (when IDLE).
- Reset (rst=0, any time, including mid-REFILL), immediately:
  - state=IDLE, cnt=0, mem_req=0, mem_addr=0;
  - all valid bits = 0;
  - tag/data arrays are not reset.
- Replacement: direct-mapped; a refill overwrites the indexed line unconditionally.

Decomposition:
- Shared package/defines header (alongside `InstAddrBus, `StallBus, `ZeroWord, `Stop/`NoStop):
  - ICACHE_INDEX_W / ICACHE_OFFSET_W defaults;
  - FSM state encodings ICS_IDLE/ICS_REFILL/ICS_DONE.
- One natural sub-module, icache_refill_fsm:
  - owns state, beat counter, mem_req/mem_addr;
  - emits write-enable/index/offset strobes to the array logic in icache_dm.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, icache_ce=1, icache_pc=0x0000_1004.
   - Response: stallreq=1; mem_req=1 with mem_addr=0x0000_1000 the next cycle.
   - Then 8 back-to-back beats 0xA0..0xA7: mem_req drops after beat 8; DONE then IDLE.
   - Finally inst=0xA1, inst_valid=1, stallreq=0.
2. Hit after fill:
   - Stimulus: icache_pc=0x0000_101C.
   - Response: same cycle inst=0xA7, inst_valid=1, no mem_req.
3. Conflict eviction:
   - Stimulus: icache_pc=0x0000_1804 (same index, different tag).
   - Response: refill at 0x0000_1800.
   - Afterwards 0x0000_1004 misses again and re-refills.
4. Beat gaps:
   - Stimulus: mem_rvalid toggling 1,0,0,1,...
   - Response: mem_addr stable; exactly 8 words written in order; no early valid.
5. Flush mid-refill:
   - Stimulus: flush pulse at beat 3 (upstream drops ce).
   - Response: refill completes, line installed.
   - Later fetch of that line hits with zero mem_req.
6. Reset mid-refill:
   - Stimulus: rst=0 at beat 5.
   - Response: mem_req=0 immediately, all lines invalid.
   - Refetch of the same pc misses and requests 0x0000_1000 again.
